// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense controller and the vending FSM top.
package vend_pkg;

  localparam int PROD_W_DEF       = 3;
  localparam int CRED_W_DEF       = 3;
  localparam int MOTOR_CYCLES_DEF = 8;
  localparam int CHANGE_HI_DEF    = 2;
  localparam int CHANGE_LO_DEF    = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOTOR  = 3'd1,
    ST_CHG_HI = 3'd2,
    ST_CHG_LO = 3'd3,
    ST_DONE   = 3'd4
  } vend_state_e;

  // First phase of a freshly started job: the motor is skipped for product 0,
  // and the change phase is skipped when there is nothing to return.
  function automatic vend_state_e first_phase(input logic has_prod, input logic has_cred);
    if (has_prod) return ST_MOTOR;
    if (has_cred) return ST_CHG_HI;
    return ST_DONE;
  endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Dispense request bus from the vending FSM to the dispense controller.
interface vend_dispense_ctrl_if #(
  parameter int PROD_W = vend_pkg::PROD_W_DEF,
  parameter int CRED_W = vend_pkg::CRED_W_DEF
);
  logic              disp_i;
  logic [PROD_W-1:0] prod_i;
  logic [CRED_W-1:0] credit_i;

  modport master (output disp_i, prod_i, credit_i);
  modport slave  (input  disp_i, prod_i, credit_i);
endinterface

// File: rtl/vend_phase_timer.sv
// Loadable phase down-counter; o_expire marks the last cycle of a phase.
module vend_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  // Load on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense job controller: slot motor drive, coin-return pulses, completion flag,
// with a one-deep pending buffer for requests arriving mid-job.
//   state   | meaning
//   IDLE    | no job
//   MOTOR   | slot motor driven for MOTOR_CYCLES
//   CHG_HI  | coin-return pulse high
//   CHG_LO  | coin-return gap, one credit unit retired at its end
//   DONE    | one-cycle completion, next job may start here
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int PROD_W       = PROD_W_DEF,
  parameter int CRED_W       = CRED_W_DEF,
  parameter int MOTOR_CYCLES = MOTOR_CYCLES_DEF,
  parameter int CHANGE_HI    = CHANGE_HI_DEF,
  parameter int CHANGE_LO    = CHANGE_LO_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  vend_dispense_ctrl_if.slave  req,
  output logic [2**PROD_W-1:0] motor_o,
  output logic                 change_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pend_o,
  output logic                 ovf_o
);

  localparam int MOTOR_W = 2**PROD_W;
  localparam int MAX_A   = (MOTOR_CYCLES > CHANGE_HI) ? MOTOR_CYCLES : CHANGE_HI;
  localparam int MAX_CYC = (MAX_A > CHANGE_LO) ? MAX_A : CHANGE_LO;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  vend_state_e       r_state, w_nxt;
  logic [PROD_W-1:0] r_prod, r_pend_prod, w_job_prod, w_prod_nxt;
  logic [CRED_W-1:0] r_cred, r_pend_cred, w_job_cred;
  logic              r_pend_v, r_ovf;
  logic              w_take_pend, w_start, w_busy_req, w_expire, w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_val;

  // Job source selection and next-state decision.
  always_comb begin
    w_take_pend = (r_state == ST_DONE) && r_pend_v;
    w_start     = w_take_pend ||
                  (req.disp_i && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && !r_pend_v)));
    w_job_prod  = w_take_pend ? r_pend_prod : req.prod_i;
    w_job_cred  = w_take_pend ? r_pend_cred : req.credit_i;
    w_prod_nxt  = w_start ? w_job_prod : r_prod;
    w_busy_req  = req.disp_i &&
                  ((r_state == ST_MOTOR) || (r_state == ST_CHG_HI) || (r_state == ST_CHG_LO));
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_nxt = first_phase(w_job_prod != '0, w_job_cred != '0);
      ST_MOTOR:  if (w_expire) w_nxt = (r_cred != '0) ? ST_CHG_HI : ST_DONE;
      ST_CHG_HI: if (w_expire) w_nxt = ST_CHG_LO;
      ST_CHG_LO: if (w_expire) w_nxt = (r_cred > CRED_W'(1)) ? ST_CHG_HI : ST_DONE;
      ST_DONE:   w_nxt = w_start ? first_phase(w_job_prod != '0, w_job_cred != '0) : ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // Every phase is entered from a different state, so a state change reloads the timer.
  always_comb begin
    w_tmr_load = (w_nxt != r_state);
    case (w_nxt)
      ST_MOTOR:  w_tmr_val = CNT_W'(MOTOR_CYCLES);
      ST_CHG_HI: w_tmr_val = CNT_W'(CHANGE_HI);
      ST_CHG_LO: w_tmr_val = CNT_W'(CHANGE_LO);
      default:   w_tmr_val = '0;
    endcase
  end

  vend_phase_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_expire)
  );

  // State, job/pending registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prod      <= '0;
      r_cred      <= '0;
      r_pend_v    <= 1'b0;
      r_pend_prod <= '0;
      r_pend_cred <= '0;
      r_ovf       <= 1'b0;
      motor_o     <= '0;
      change_o    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      busy_o   <= (w_nxt != ST_IDLE);
      done_o   <= (w_nxt == ST_DONE);
      change_o <= (w_nxt == ST_CHG_HI);
      motor_o  <= (w_nxt == ST_MOTOR) ? (MOTOR_W'(1) << w_prod_nxt) : '0;

      if (w_start) begin
        r_prod <= w_job_prod;
        r_cred <= w_job_cred;
      end else if ((r_state == ST_CHG_LO) && w_expire && (r_cred != '0)) begin
        r_cred <= r_cred - CRED_W'(1);
      end

      // A request in DONE while the buffer is full refills the slot just consumed.
      if (w_busy_req) begin
        if (!r_pend_v) begin
          r_pend_v    <= 1'b1;
          r_pend_prod <= req.prod_i;
          r_pend_cred <= req.credit_i;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if ((r_state == ST_DONE) && r_pend_v) begin
        if (req.disp_i) begin
          r_pend_prod <= req.prod_i;
          r_pend_cred <= req.credit_i;
        end else begin
          r_pend_v <= 1'b0;
        end
      end
    end
  end

  assign pend_o = r_pend_v;
  assign ovf_o  = r_ovf;

endmodule
